// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between the control unit and the HI/LO multiply-divide unit.
// master = control side (issues ops, stalls on busy), slave = the unit itself.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// state | meaning
// IDLE  | waiting for an issue; MTHI/MTLO write HI/LO here
// CALC  | one radix-2 step per clock (shift-add / restoring divide), busy high
// DONE  | HI/LO just written, done high; a new issue is accepted here
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_hilo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     acc, acc_step;
  logic [WIDTH-1:0]       opnd;
  logic                   mul_op, neg_res, neg_rem;
  logic [WIDTH-1:0]       hi_q, lo_q, res_hi, res_lo;
  logic                   do_load, do_mthi, do_mtlo, do_step, do_finish;
  logic                   signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum, div_trial;
  logic [2*WIDTH-1:0]     prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_mthi   = 1'b0;
    do_mtlo   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state)
      S_CALC: begin
        if (bus.flush) begin
          state_nxt = S_IDLE;
        end else begin
          do_step = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            do_finish = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        if (bus.start && !bus.flush) begin
          case (bus.op)
            3'b100: do_mthi = 1'b1;
            3'b101: do_mtlo = 1'b1;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              do_load   = 1'b1;
              state_nxt = S_CALC;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Operand magnitudes and the per-iteration step for both algorithms.
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.op_a[WIDTH-1];
    b_neg     = signed_op & bus.op_b[WIDTH-1];
    a_mag     = a_neg ? -bus.op_a : bus.op_a;
    b_mag     = b_neg ? -bus.op_b : bus.op_b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (mul_op)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_trial[WIDTH])
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod = neg_res ? -acc_step : acc_step;
    if (mul_op) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_hi = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      res_lo = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      mul_op  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (do_mthi) hi_q <= bus.op_a;
      if (do_mtlo) lo_q <= bus.op_a;
      if (do_load) begin
        cnt    <= '0;
        mul_op <= ~bus.op[1];
        if (!bus.op[1]) begin
          opnd    <= a_mag;
          acc     <= {{WIDTH{1'b0}}, b_mag};
          neg_res <= a_neg ^ b_neg;
          neg_rem <= 1'b0;
        end else if (bus.op_b == '0) begin
          // Divisor 0 replays the raw dividend into the remainder and an all-ones quotient.
          opnd    <= '0;
          acc     <= {{WIDTH{1'b0}}, bus.op_a};
          neg_res <= 1'b0;
          neg_rem <= 1'b0;
        end else begin
          opnd    <= b_mag;
          acc     <= {{WIDTH{1'b0}}, a_mag};
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
        end
      end
      if (do_step) begin
        cnt <= cnt + 1'b1;
        acc <= acc_step;
      end
      if (do_finish) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy = (state == S_CALC);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed cases plus random mul/div against
// a plain-arithmetic reference model.
module tb_muldiv_hilo;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_hilo_if #(.WIDTH(32)) bus ();

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {hi, lo} expected from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, q, r;
    logic [63:0] ua, ub, res;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      3'b000: begin q = sa * sb; res = q; end
      3'b001: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 3'b010) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {(ua % ub) << 32} | (ua / ub);
        end
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Issue one op and wait (bounded) for busy to drop; reports cycles and HI/LO stability.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output bit stable);
    logic [31:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    issue(o, a, b);
    cycles = 0;
    stable = 1'b1;
    while (bus.busy && cycles < 40) begin
      if (bus.hi !== hi0 || bus.lo !== lo0) stable = 1'b0;
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'b000; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    #3;
    n_checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b011};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [63:0] exp [5] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                             64'h0000_0000_8000_0000, 64'h1234_5678_FFFF_FFFF};
    int cyc;
    bit stable;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], cyc, stable);
      n_checks++;
      if (cyc != 32) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: busy cycles=%0d, want 32", i, cyc);
      end
      n_checks++;
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_done[%0d]: done=%b, want 1", i, bus.done);
      end
      n_checks++;
      if ({bus.hi, bus.lo} !== exp[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: hi:lo=%h, want %h", i, {bus.hi, bus.lo}, exp[i]);
      end
      n_checks++;
      if (!stable) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: hi/lo changed during CALC, want stable", i);
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_pulse[%0d]: done=%b one cycle later, want 0", i, bus.done);
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    bit stable;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = (i % 6 == 5) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp = model(o, a, b);
      run_op(o, a, b, cyc, stable);
      n_checks++;
      if (cyc != 32 || !stable || bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: cycles=%0d stable=%b done=%b, want 32/1/1", i, cyc, stable, bus.done);
      end
      n_checks++;
      if ({bus.hi, bus.lo} !== exp) begin
        n_fail++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h: hi:lo=%h, want %h", i, o, a, b, {bus.hi, bus.lo}, exp);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit stable;
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7, cyc, stable);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL mult_neg: hi:lo=%h done=%b, want ffffffffffffffeb done=1", {bus.hi, bus.lo}, bus.done);
    end
    issue(3'b001, 32'd2, 32'd3);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1/0", bus.busy, bus.done);
    end
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32 || bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
      n_fail++;
      $display("FAIL b2b_result: cycles=%0d done=%b hi=%h lo=%h, want 32/1/0/6", cyc, bus.done, bus.hi, bus.lo);
    end
    tick();
  endtask

  task automatic test_mthi_flush();
    logic [31:0] lo_keep;
    bit saw_done;
    issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    n_checks++;
    if (bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: hi=%h busy=%b done=%b, want deadbeef/0/0", bus.hi, bus.busy, bus.done);
    end
    lo_keep = bus.lo;
    issue(3'b011, 32'd10, 32'd3);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_a = 32'h55;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.lo !== lo_keep || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mtlo_in_calc: lo=%h busy=%b, want %h/1", bus.lo, bus.busy, lo_keep);
    end
    repeat (8) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'hDEAD_BEEF || bus.lo !== lo_keep) begin
      n_fail++;
      $display("FAIL flush: busy=%b done=%b hi=%h lo=%h, want 0/0/deadbeef/%h", bus.busy, bus.done, bus.hi, bus.lo, lo_keep);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL flush_quiet: saw busy/done after flush=%b, want 0", saw_done);
    end
    bus.flush = 1'b1;
    issue(3'b100, 32'h1234_5678, 32'd0);
    bus.flush = 1'b0;
    n_checks++;
    if (bus.hi !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL flush_blocks_start: hi=%h, want deadbeef", bus.hi);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    bit stable;
    issue(3'b000, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (14) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(3'b001, 32'd4, 32'd5, cyc, stable);
    n_checks++;
    if (cyc != 32 || bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'h14) begin
      n_fail++;
      $display("FAIL post_reset_multu: cycles=%0d done=%b hi=%h lo=%h, want 32/1/0/14", cyc, bus.done, bus.hi, bus.lo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mthi_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
